// File: rtl/vdp_cmd_sequencer.sv
`timescale 1ns/1ps
// vdp_cmd_sequencer
// Host-side initiator for the VDP CPU bus. Accepts one command at a time from
// a valid/ready stream and expands it into a sequence of (mode, data) write
// beats. Every strobe is followed by GAP_CYCLES cycles with vdp_write low so
// the VDP can post-increment its write address.
//
// Optional feature macro: VDP_CMD_FILL_EN
//   defined   -> FILL issues cmd_count beats using a 16-bit down-counter
//   undefined -> the counter is compiled out and FILL behaves as VRAM_WRITE

module vdp_cmd_sequencer #(
   parameter int GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_addr,
   input  logic [7:0]  cmd_data,
   input  logic [15:0] cmd_count,
   output logic [1:0]  vdp_mode,
   output logic        vdp_write,
   output logic [7:0]  vdp_data,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [1:0] OP_REG   = 2'd0;
   localparam logic [1:0] OP_WADDR = 2'd1;
   localparam logic [1:0] OP_VRAM  = 2'd2;

   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

`ifdef VDP_CMD_FILL_EN
   localparam int REM_W = 16;
`else
   localparam int REM_W = 2;
`endif
   localparam int NB_W = REM_W + 1;

   state_t r_state;
   state_t w_nextState;

   logic [1:0]       r_op;
   logic [7:0]       r_addr;
   logic [7:0]       r_cmdData;
   logic [15:0]      r_count;
   logic [1:0]       r_beatIdx;
   logic [REM_W-1:0] r_remain;
   logic [3:0]       r_gapCnt;

   logic       r_ready;
   logic       r_busy;
   logic       r_done;
   logic       r_write;
   logic [1:0] r_mode;
   logic [7:0] r_vdpData;

   logic             w_accept;
   logic             w_gapEnd;
   logic [1:0]       w_srcOp;
   logic [7:0]       w_srcAddr;
   logic [7:0]       w_srcData;
   logic [15:0]      w_srcCount;
   logic [1:0]       w_idx;
   logic [NB_W-1:0]  w_numBeats;
   logic [REM_W-1:0] w_remainInit;
   logic [1:0]       w_beatMode;
   logic [7:0]       w_beatData;

   // A command is taken only when the registered ready is up, so the first
   // cycle after reset can never accept.
   assign w_accept = (r_state == ST_IDLE) && r_ready && cmd_valid;
   assign w_gapEnd = (r_state == ST_GAP) && (r_gapCnt == 4'd0);

   // On the accept edge the beat is built from the live command fields,
   // afterwards from the latched copy.
   assign w_srcOp    = w_accept ? cmd_op    : r_op;
   assign w_srcAddr  = w_accept ? cmd_addr  : r_addr;
   assign w_srcData  = w_accept ? cmd_data  : r_cmdData;
   assign w_srcCount = w_accept ? cmd_count : r_count;
   assign w_idx      = w_accept ? 2'd0 : r_beatIdx + 2'd1;

   assign w_remainInit = REM_W'(w_numBeats - NB_W'(1));

   // Total beat count of the command being offered on the stream.
   always_comb begin
      w_numBeats = NB_W'(1);
      case (cmd_op)
         OP_REG:   w_numBeats = NB_W'(2);
         OP_WADDR: w_numBeats = NB_W'(4);
         OP_VRAM:  w_numBeats = NB_W'(1);
`ifdef VDP_CMD_FILL_EN
         default:  w_numBeats = NB_W'(cmd_count);
`else
         default:  w_numBeats = NB_W'(1);
`endif
      endcase
   end

   // Mode/data pair of the beat about to be strobed.
   always_comb begin
      w_beatMode = 2'd2;
      w_beatData = w_srcData;
      case (w_srcOp)
         OP_REG: begin
            w_beatMode = {1'b0, w_idx[0]};
            w_beatData = w_idx[0] ? w_srcData : w_srcAddr;
         end
         OP_WADDR: begin
            w_beatMode = {1'b0, w_idx[0]};
            case (w_idx)
               2'd0:    w_beatData = 8'h02;
               2'd1:    w_beatData = w_srcCount[7:0];
               2'd2:    w_beatData = 8'h03;
               default: w_beatData = w_srcCount[15:8];
            endcase
         end
         default: begin
            w_beatMode = 2'd2;
            w_beatData = w_srcData;
         end
      endcase
   end

   // Next-state logic; a zero-length FILL skips straight to DONE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_nextState = (w_numBeats == '0) ? ST_DONE : ST_STROBE;
            end
         end
         ST_STROBE: w_nextState = ST_GAP;
         ST_GAP: begin
            if (w_gapEnd) begin
               w_nextState = (r_remain != '0) ? ST_STROBE : ST_DONE;
            end
         end
         ST_DONE: w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // State register; reset abandons any command in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Command latch, remaining-beat counter and gap timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op      <= 2'd0;
         r_addr    <= 8'd0;
         r_cmdData <= 8'd0;
         r_count   <= 16'd0;
         r_remain  <= '0;
         r_beatIdx <= 2'd0;
         r_gapCnt  <= 4'd0;
      end else begin
         if (w_accept) begin
            r_op      <= cmd_op;
            r_addr    <= cmd_addr;
            r_cmdData <= cmd_data;
            r_count   <= cmd_count;
            r_remain  <= w_remainInit;
            r_beatIdx <= 2'd0;
         end else if (w_gapEnd && (r_remain != '0)) begin
            r_remain  <= r_remain - REM_W'(1);
            r_beatIdx <= w_idx;
         end
         if (r_state == ST_STROBE) begin
            r_gapCnt <= GAP_LAST;
         end else if ((r_state == ST_GAP) && (r_gapCnt != 4'd0)) begin
            r_gapCnt <= r_gapCnt - 4'd1;
         end
      end
   end

   // Registered outputs, derived from the state being entered so they line
   // up with that state's cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_write   <= 1'b0;
         r_mode    <= 2'd0;
         r_vdpData <= 8'd0;
      end else begin
         r_ready <= (w_nextState == ST_IDLE);
         r_busy  <= (w_nextState != ST_IDLE);
         r_done  <= (w_nextState == ST_DONE);
         case (w_nextState)
            ST_STROBE: begin
               r_write   <= 1'b1;
               r_mode    <= w_beatMode;
               r_vdpData <= w_beatData;
            end
            ST_GAP: begin
               r_write <= 1'b0;
            end
            default: begin
               r_write   <= 1'b0;
               r_mode    <= 2'd0;
               r_vdpData <= 8'd0;
            end
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign vdp_write = r_write;
   assign vdp_mode  = r_mode;
   assign vdp_data  = r_vdpData;

endmodule

// File: tb/tb_vdp_cmd_sequencer.sv
`timescale 1ns/1ps
// tb_vdp_cmd_sequencer
// Self-checking bench: a table of directed commands, hand-written reset and
// back-to-back sequences, and randomized commands compared against a beat-list
// model built directly from the command rules.

module tb_vdp_cmd_sequencer;

   localparam int GAP    = 2;
   localparam int PERIOD = 1 + GAP;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic [15:0] cmd_count;
   logic [1:0]  vdp_mode;
   logic        vdp_write;
   logic [7:0]  vdp_data;
   logic        busy;
   logic        done;

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] data;
   } beat_t;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [15:0] count;
      int          nBeats;
      logic [9:0]  firstBeat;
      logic [9:0]  lastBeat;
      int          doneOff;
   } vec_t;

   int    vectors     = 0;
   int    miscompares = 0;
   int    cycleNo     = 0;
   int    lastStrobe  = -100;
   beat_t expBeats[$];
   beat_t gotBeats[$];
   int    gotOffs[$];
   int    gotDoneOff;
   int    gotReadyAfter;
   int    busyDrops;
   logic [7:0]  vdpSel  = 8'd0;
   logic [15:0] vdpAddr = 16'd0;
   vec_t  vecs[5];

   vdp_cmd_sequencer #(.GAP_CYCLES(GAP)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .vdp_mode  (vdp_mode),
      .vdp_write (vdp_write),
      .vdp_data  (vdp_data),
      .busy      (busy),
      .done      (done)
   );

   // Free-running clock and cycle counter used for strobe spacing.
   always #5 clk = ~clk;

   always @(posedge clk) cycleNo <= cycleNo + 1;

   // Hard time limit so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   // Reference beat list for a command.
   task automatic buildBeats(input logic [1:0] op, input logic [7:0] addr,
                             input logic [7:0] data, input logic [15:0] count);
      beat_t b;
      expBeats.delete();
      case (op)
         2'd0: begin
            b.mode = 2'd0; b.data = addr;         expBeats.push_back(b);
            b.mode = 2'd1; b.data = data;         expBeats.push_back(b);
         end
         2'd1: begin
            b.mode = 2'd0; b.data = 8'h02;        expBeats.push_back(b);
            b.mode = 2'd1; b.data = count[7:0];   expBeats.push_back(b);
            b.mode = 2'd0; b.data = 8'h03;        expBeats.push_back(b);
            b.mode = 2'd1; b.data = count[15:8];  expBeats.push_back(b);
         end
         2'd2: begin
            b.mode = 2'd2; b.data = data;         expBeats.push_back(b);
         end
         default: begin
            b.mode = 2'd2; b.data = data;
`ifdef VDP_CMD_FILL_EN
            for (int i = 0; i < int'(count); i++) expBeats.push_back(b);
`else
            expBeats.push_back(b);
`endif
         end
      endcase
   endtask

   // Offer one command, wait for its accept edge, then record every strobe
   // (offset from the accept edge), the done offset and ready after done.
   task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr,
                                input logic [7:0] data, input logic [15:0] count);
      int    waitCnt;
      int    limit;
      beat_t b;
      gotBeats.delete();
      gotOffs.delete();
      gotDoneOff    = -1;
      gotReadyAfter = 0;
      busyDrops     = 0;
      @(negedge clk);
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_count = count;
      cmd_valid = 1'b1;
      waitCnt   = 0;
      while (!cmd_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!cmd_ready) begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      limit = (op == 2'd3) ? 1 + (4 + int'(count)) * PERIOD + 8 : 1 + 4 * PERIOD + 8;
      for (int off = 1; off <= limit; off++) begin
         if (off > 1) begin
            @(posedge clk);
            #1;
         end
         if (vdp_write) begin
            b.mode = vdp_mode;
            b.data = vdp_data;
            gotBeats.push_back(b);
            gotOffs.push_back(off);
            checkOutput("strobeSpacingOk", 32'(cycleNo - lastStrobe >= PERIOD), 32'd1);
            lastStrobe = cycleNo;
            case (vdp_mode)
               2'd0: vdpSel = vdp_data;
               2'd1: begin
                  if (vdpSel == 8'd2) vdpAddr[7:0]  = vdp_data;
                  if (vdpSel == 8'd3) vdpAddr[15:8] = vdp_data;
               end
               2'd2: vdpAddr = vdpAddr + 16'd1;
               default: ;
            endcase
         end
         if (gotDoneOff < 0 && !busy) busyDrops++;
         if (done && gotDoneOff < 0) gotDoneOff = off;
         if (gotDoneOff >= 0 && off == gotDoneOff + 1) begin
            gotReadyAfter = int'(cmd_ready);
            break;
         end
      end
   endtask

   // Compare the recorded trace against the reference beat list.
   task automatic checkOutputTrace(input string tag);
      int n;
      n = expBeats.size();
      checkOutput({tag, ".beats"}, 32'(gotBeats.size()), 32'(n));
      for (int k = 0; k < n && k < gotBeats.size(); k++) begin
         checkOutput({tag, ".beat"}, {22'd0, gotBeats[k]}, {22'd0, expBeats[k]});
         checkOutput({tag, ".strobeOff"}, 32'(gotOffs[k]), 32'(1 + k * PERIOD));
      end
      checkOutput({tag, ".doneOff"}, 32'(gotDoneOff), 32'(1 + n * PERIOD));
      checkOutput({tag, ".readyAfterDone"}, 32'(gotReadyAfter), 32'd1);
      checkOutput({tag, ".busyDrops"}, 32'(busyDrops), 32'd0);
   endtask

   initial begin
      logic [9:0]  gotFirst;
      logic [9:0]  gotLast;
      logic [1:0]  rop;
      logic [15:0] rcount;
      int          writes;
      int          dones;
      int          strobes;
      int          readies;
      int          prevStrobe;
      int          doubleReady;
      logic        prevReady;

      vecs[0] = '{2'd0, 8'h04, 8'h50, 16'h0000, 2, 10'h004, 10'h150, 1 + 2 * PERIOD};
      vecs[1] = '{2'd1, 8'h00, 8'h00, 16'h1234, 4, 10'h002, 10'h112, 1 + 4 * PERIOD};
      vecs[2] = '{2'd2, 8'h00, 8'h5A, 16'h0000, 1, 10'h25A, 10'h25A, 1 + PERIOD};
`ifdef VDP_CMD_FILL_EN
      vecs[3] = '{2'd3, 8'h00, 8'hAA, 16'd3,    3, 10'h2AA, 10'h2AA, 1 + 3 * PERIOD};
      vecs[4] = '{2'd3, 8'h00, 8'h77, 16'd0,    0, 10'h3FF, 10'h3FF, 1};
`else
      vecs[3] = '{2'd3, 8'h00, 8'hAA, 16'd3,    1, 10'h2AA, 10'h2AA, 1 + PERIOD};
      vecs[4] = '{2'd3, 8'h00, 8'h77, 16'd0,    1, 10'h277, 10'h277, 1 + PERIOD};
`endif

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_addr  = 8'd0;
      cmd_data  = 8'd0;
      cmd_count = 16'd0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst.write", 32'(vdp_write), 32'd0);
      checkOutput("rst.mode",  32'(vdp_mode),  32'd0);
      checkOutput("rst.data",  32'(vdp_data),  32'd0);
      checkOutput("rst.busy",  32'(busy),      32'd0);
      checkOutput("rst.done",  32'(done),      32'd0);
      checkOutput("rst.ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstRelease.ready", 32'(cmd_ready), 32'd1);

      // Directed table.
      for (int v = 0; v < 5; v++) begin
         buildBeats(vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].count);
         applyStimulus(vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].count);
         gotFirst = (gotBeats.size() > 0) ? gotBeats[0] : 10'h3FF;
         gotLast  = (gotBeats.size() > 0) ? gotBeats[gotBeats.size() - 1] : 10'h3FF;
         checkOutput($sformatf("vec%0d.nBeats", v), 32'(gotBeats.size()), 32'(vecs[v].nBeats));
         checkOutput($sformatf("vec%0d.first", v), {22'd0, gotFirst}, {22'd0, vecs[v].firstBeat});
         checkOutput($sformatf("vec%0d.last", v), {22'd0, gotLast}, {22'd0, vecs[v].lastBeat});
         checkOutput($sformatf("vec%0d.doneOff", v), 32'(gotDoneOff), 32'(vecs[v].doneOff));
         checkOutputTrace($sformatf("vec%0d", v));
      end
`ifdef VDP_CMD_FILL_EN
      checkOutput("vdpModel.waddr", 32'(vdpAddr), 32'h1238);
`else
      checkOutput("vdpModel.waddr", 32'(vdpAddr), 32'h1237);
`endif

      // Reset during the second beat of SET_WADDR.
      @(negedge clk);
      cmd_op    = 2'd1;
      cmd_count = 16'hBEEF;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (PERIOD) @(posedge clk);
      #1;
      checkOutput("rstMid.secondWrite", 32'(vdp_write), 32'd1);
      checkOutput("rstMid.secondBeat", {22'd0, vdp_mode, vdp_data}, 32'h1EF);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstMid.writeLow", 32'(vdp_write), 32'd0);
      checkOutput("rstMid.busy",     32'(busy),      32'd0);
      checkOutput("rstMid.done",     32'(done),      32'd0);
      checkOutput("rstMid.ready",    32'(cmd_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstMid.readyAfter", 32'(cmd_ready), 32'd1);
      writes = 0;
      dones  = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (vdp_write) writes++;
         if (done) dones++;
      end
      checkOutput("rstMid.noMoreWrites", 32'(writes), 32'd0);
      checkOutput("rstMid.noDone",       32'(dones),  32'd0);
      buildBeats(2'd2, 8'h00, 8'h99, 16'h0000);
      applyStimulus(2'd2, 8'h00, 8'h99, 16'h0000);
      checkOutputTrace("postRst");

      // Randomized commands against the beat-list model.
      for (int r = 0; r < 25; r++) begin
         rop    = 2'($urandom_range(0, 3));
         rcount = (rop == 2'd3) ? 16'($urandom_range(0, 5)) : 16'($urandom);
         cmd_addr = 8'($urandom);
         buildBeats(rop, cmd_addr, 8'(r * 37 + 5), rcount);
         applyStimulus(rop, cmd_addr, 8'(r * 37 + 5), rcount);
         checkOutputTrace($sformatf("rand%0d", r));
      end

      // cmd_valid held high with back-to-back VRAM_WRITEs.
      @(negedge clk);
      cmd_op      = 2'd2;
      cmd_data    = 8'h3C;
      cmd_valid   = 1'b1;
      strobes     = 0;
      readies     = 0;
      dones       = 0;
      prevStrobe  = -1;
      doubleReady = 0;
      prevReady   = 1'b0;
      for (int i = 0; i < 6 * (PERIOD + 2); i++) begin
         @(posedge clk);
         #1;
         if (vdp_write) begin
            if (prevStrobe >= 0) checkOutput("b2b.spacing", 32'(i - prevStrobe), 32'(PERIOD + 2));
            prevStrobe = i;
            strobes++;
         end
         if (cmd_ready) readies++;
         if (cmd_ready && prevReady) doubleReady++;
         if (done) dones++;
         prevReady = cmd_ready;
      end
      cmd_valid = 1'b0;
      checkOutput("b2b.strobes",     32'(strobes),     32'd6);
      checkOutput("b2b.accepts",     32'(readies),     32'd6);
      checkOutput("b2b.dones",       32'(dones),       32'd6);
      checkOutput("b2b.doubleReady", 32'(doubleReady), 32'd0);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
